// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier.
//   state_t      : sequencer states (IDLE, RUN, DONE)
//   booth_sel_t  : addend selection for one 3-bit Booth window
//   booth_decode : maps {q[1], q[0], q_m1} to the addend selection
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_PM,
        SEL_P2M,
        SEL_NM,
        SEL_N2M
    } booth_sel_t;

    function automatic booth_sel_t booth_decode(input logic [2:0] win);
        booth_sel_t sel;
        case (win)
            3'b001, 3'b010: sel = SEL_PM;
            3'b011:         sel = SEL_P2M;
            3'b100:         sel = SEL_N2M;
            3'b101, 3'b110: sel = SEL_NM;
            default:        sel = SEL_ZERO;  // 000 and 111
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth encoder: turns one 3-bit multiplier window into the addend
// 0, +M, +2M, -M or -2M at accumulator width.
//   window : {q_reg[1], q_reg[0], q_m1}
//   m_ext  : multiplicand already sign/zero extended to DW+2 bits
//   addend : selected value, DW+3 bits two's complement
module booth_r4_encoder
    import booth_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [2:0]    window,
    input  logic [DW+1:0] m_ext,
    output logic [DW+2:0] addend
);

    localparam int AW = DW + 3;

    logic [AW-1:0] m_aw;
    logic [AW-1:0] m2_aw;

    assign m_aw  = {m_ext[DW+1], m_ext};
    assign m2_aw = m_aw << 1;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        addend = '0;
        case (booth_decode(window))
            SEL_PM:  addend = m_aw;
            SEL_P2M: addend = m2_aw;
            SEL_NM:  addend = -m_aw;
            SEL_N2M: addend = -m2_aw;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_mult.sv
// Self-sequencing radix-4 Booth multiplier, signed or unsigned per operation.
// Retires two multiplier bits per cycle; a result takes DW/2+1 iterations.
//   clk, reset   : rising-edge clock, synchronous active-low reset
//   start        : request, accepted whenever no operation is running
//   signed_mode  : 1 = two's complement operands, 0 = unsigned
//   multiplicand : operand M, sampled with an accepted start
//   multiplier   : operand Q, sampled with an accepted start
//   busy         : high while iterating
//   done         : one-cycle pulse when product is updated
//   product      : 2*DW-bit result, held until the next result is written
module booth_radix4_mult
    import booth_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            signed_mode,
    input  logic [DW-1:0]   multiplicand,
    input  logic [DW-1:0]   multiplier,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] product
);

    localparam int ITER = DW / 2 + 1;
    localparam int AW   = DW + 3;
    localparam int QW   = DW + 2;
    localparam int CW   = $clog2(ITER + 1);

    if ((DW % 2) != 0 || DW < 4) begin : g_bad_dw
        $error("booth_radix4_mult: DW must be even and >= 4");
    end

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [QW-1:0]   q_reg_q, q_reg_d;
    logic [QW-1:0]   m_q, m_d;
    logic            q_m1_q, q_m1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2*DW-1:0] product_q, product_d;

    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic            accept;

    booth_r4_encoder #(.DW(DW)) u_enc (
        .window (({q_reg_q[1:0], q_m1_q})),
        .m_ext  (m_q),
        .addend (addend)
    );

    assign sum    = acc_q + addend;
    // Operands are taken in IDLE and also in DONE, giving back-to-back runs.
    assign accept = start && (state_q != RUN);

    // NOTE: combinational next-state logic uses blocking assignments; the
    // registers below take those values with non-blocking assignments only.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_reg_d   = q_reg_q;
        m_d       = m_q;
        q_m1_d    = q_m1_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            RUN: begin
                // Arithmetic shift of {acc, q_reg, q_m1} right by two.
                acc_d   = {{2{sum[AW-1]}}, sum[AW-1:2]};
                q_reg_d = {sum[1:0], q_reg_q[QW-1:2]};
                q_m1_d  = q_reg_q[1];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // {acc, q_reg} now equals M*Q; keep its low 2*DW bits.
                    product_d = {acc_d[DW-3:0], q_reg_d};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        if (accept) begin
            m_d     = signed_mode ? {{2{multiplicand[DW-1]}}, multiplicand}
                                  : {2'b00, multiplicand};
            q_reg_d = signed_mode ? {{2{multiplier[DW-1]}}, multiplier}
                                  : {2'b00, multiplier};
            acc_d   = '0;
            q_m1_d  = 1'b0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
        end
    end

    // NOTE: operand registers are reset along with the control state so an
    // abandoned run leaves no stale data visible after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            q_reg_q   <= '0;
            m_q       <= '0;
            q_m1_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_reg_q   <= q_reg_d;
            m_q       <= m_d;
            q_m1_q    <= q_m1_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Directed bench for booth_radix4_mult at DW=8 and DW=16.
module tb_booth_radix4_mult;

    logic        clk = 1'b0;
    logic        reset;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  m8, q8;
    logic [15:0] prod8;

    logic        start16, sm16, busy16, done16;
    logic [15:0] m16, q16;
    logic [31:0] prod16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_radix4_mult #(.DW(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .start        (start8),
        .signed_mode  (sm8),
        .multiplicand (m8),
        .multiplier   (q8),
        .busy         (busy8),
        .done         (done8),
        .product      (prod8)
    );

    booth_radix4_mult #(.DW(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .start        (start16),
        .signed_mode  (sm16),
        .multiplicand (m16),
        .multiplier   (q16),
        .busy         (busy16),
        .done         (done16),
        .product      (prod16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_8(input logic sm, input logic [7:0] m, input logic [7:0] q);
        sm8 = sm; m8 = m; q8 = q; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen (bounded).
    task automatic wait_done_8(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (!done8 && cycles < 40) begin
            if (busy8) busy_cycles++;
            tick();
            cycles++;
        end
    endtask

    task automatic run_8(input string tag, input logic sm, input logic [7:0] m,
                         input logic [7:0] q, input logic [15:0] exp);
        int c, b;
        start_8(sm, m, q);
        wait_done_8(c, b);
        check({tag, "_lat"}, c, 5);
        check({tag, "_prod"}, prod8, exp);
    endtask

    function automatic logic [31:0] ref_mul16(input logic sm, input logic [15:0] m,
                                              input logic [15:0] q);
        longint a, b;
        a = sm ? longint'($signed(m)) : longint'(m);
        b = sm ? longint'($signed(q)) : longint'(q);
        return 32'(a * b);
    endfunction

    task automatic run_16(input string tag, input logic sm, input logic [15:0] m,
                          input logic [15:0] q);
        int c;
        sm16 = sm; m16 = m; q16 = q; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        c = 0;
        while (!done16 && c < 60) begin
            tick();
            c++;
        end
        check({tag, "_lat"}, c, 9);
        check({tag, "_prod"}, prod16, ref_mul16(sm, m, q));
    endtask

    initial begin
        int c, b, ndone;
        reset = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
        start16 = 1'b0; sm16 = 1'b0; m16 = '0; q16 = '0;
        tick();
        tick();
        reset = 1'b1;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_prod8", prod8, 0);
        check("rst_busy16", busy16, 0);
        check("rst_prod16", prod16, 0);

        // -7 * 3 with busy window and one-cycle done.
        start_8(1'b1, 8'hF9, 8'h03);
        check("t1_busy_after_start", busy8, 1);
        wait_done_8(c, b);
        check("t1_lat", c, 5);
        check("t1_busy_cycles", b, 5);
        check("t1_busy_at_done", busy8, 0);
        check("t1_prod", prod8, 16'hFFEB);
        tick();
        check("t1_done_one_pulse", done8, 0);
        check("t1_prod_hold", prod8, 16'hFFEB);

        // Same bits, both modes.
        run_8("t2_unsigned_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run_8("t2_signed_ff", 1'b1, 8'hFF, 8'hFF, 16'h0001);

        // Signed corners.
        run_8("t3_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
        run_8("t3_m128_p127", 1'b1, 8'h80, 8'h7F, 16'hC080);
        run_8("t3_0_m1", 1'b1, 8'h00, 8'hFF, 16'h0000);
        run_8("t3_1_m1", 1'b1, 8'h01, 8'hFF, 16'hFFFF);
        run_8("t3_unsigned_80_7f", 1'b0, 8'h80, 8'h7F, 16'h3F80);
        tick();

        // start while busy is ignored.
        start_8(1'b1, 8'd5, 8'd6);
        tick();
        sm8 = 1'b0; m8 = 8'd9; q8 = 8'd9; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done_8(c, b);
        check("t4_lat", c, 3);
        check("t4_prod", prod8, 16'h001E);
        ndone = 0;
        repeat (8) begin
            tick();
            if (done8) ndone++;
        end
        check("t4_single_done", ndone, 0);
        check("t4_idle", busy8, 0);

        // Reset in the middle of a run.
        start_8(1'b1, 8'd7, 8'd7);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t5_busy", busy8, 0);
        check("t5_done", done8, 0);
        check("t5_prod", prod8, 0);
        ndone = 0;
        repeat (8) begin
            tick();
            if (done8) ndone++;
        end
        check("t5_no_done", ndone, 0);
        run_8("t5_3x4", 1'b1, 8'd3, 8'd4, 16'h000C);
        tick();

        // Back-to-back: start held during the DONE cycle.
        run_8("t6_first", 1'b1, 8'd6, 8'd7, 16'h002A);
        start_8(1'b1, 8'd10, 8'hFE);
        check("t6_restart_busy", busy8, 1);
        check("t6_restart_done", done8, 0);
        wait_done_8(c, b);
        check("t6_second_lat", c, 5);
        check("t6_second_prod", prod8, 16'hFFEC);

        // DW=16 corners and a mixed-mode sweep against the reference model.
        run_16("w_m32768_sq", 1'b1, 16'h8000, 16'h8000);
        run_16("w_ffff_u", 1'b0, 16'hFFFF, 16'hFFFF);
        run_16("w_ffff_s", 1'b1, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 8; i++) begin
            run_16($sformatf("w_sweep%0d", i), 1'(i % 2),
                   16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
